button_debounce: RTL

Upstream conditioning stage for every front-panel push-button. Synchronises the raw, bouncing pin, samples it on a slow divided tick through an SR_LEN-deep shift register, and emits a clean, hysteretic level `db_out`. The positive-edge detector consumes `db_out` to form the one-shot press pulse. An optional auto-repeat generator produces periodic pulses while the button is held, for fast time and alarm setting.

---
 rtl/btn_pkg.sv | 25 ++
 rtl/tick_gen.sv | 36 +++
 rtl/button_debounce.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared constants, repeat-state encoding and sizing helpers for the
// front-panel button conditioning blocks.
package btn_pkg;

  localparam int BTN_TICK_DIV     = 100000;
  localparam int BTN_SR_LEN       = 10;
  localparam int BTN_HOLD_TICKS   = 500;
  localparam int BTN_REPEAT_TICKS = 100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  function automatic int btn_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int btn_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-clk sample strobe every TICK_DIV cycles.
// Shared by the slow-rate front-panel blocks (debounce, display scan, blink).
module tick_gen #(
  parameter int TICK_DIV = btn_pkg::BTN_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  import btn_pkg::*;

  localparam int               CNT_W    = btn_cnt_width(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] counter_q;
  logic [CNT_W-1:0] counter_d;

  // With TICK_DIV=1 the counter sits at 0 and tick is high every cycle.
  assign tick = (counter_q == CNT_LAST);

  always_comb begin
    counter_d = counter_q + CNT_W'(1);
    if (tick) begin
      counter_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q <= '0;
    end else begin
      counter_q <= counter_d;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, tick-sampled shift register
// with hysteretic level output, and an optional auto-repeat strobe that is
// compiled in only when BTN_DEBOUNCE_REPEAT_EN is defined.
module button_debounce #(
  parameter int TICK_DIV     = btn_pkg::BTN_TICK_DIV,
  parameter int SR_LEN       = btn_pkg::BTN_SR_LEN,
  parameter int HOLD_TICKS   = btn_pkg::BTN_HOLD_TICKS,
  parameter int REPEAT_TICKS = btn_pkg::BTN_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic db_out,
  output logic repeat_pulse
);
  import btn_pkg::*;

  logic tick;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [SR_LEN-1:0] sr_q, sr_d;
  logic              db_out_q, db_out_d;

  // The level decision looks at the freshly shifted value so it moves on
  // the same edge as the sample; a mixed window keeps the old level.
  always_comb begin
    sync1_d  = btn_in;
    sync2_d  = sync1_q;
    sr_d     = sr_q;
    db_out_d = db_out_q;
    if (tick) begin
      sr_d = {sr_q[SR_LEN-2:0], sync2_q};
      if (&sr_d) begin
        db_out_d = 1'b1;
      end else if (~|sr_d) begin
        db_out_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sr_q     <= '0;
      db_out_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sr_q     <= sr_d;
      db_out_q <= db_out_d;
    end
  end

  assign db_out = db_out_q;

`ifdef BTN_DEBOUNCE_REPEAT_EN

  localparam int                RCNT_W      = btn_cnt_width(btn_max(HOLD_TICKS, REPEAT_TICKS));
  localparam logic [RCNT_W-1:0] HOLD_LAST   = RCNT_W'(HOLD_TICKS - 1);
  localparam logic [RCNT_W-1:0] REPEAT_LAST = RCNT_W'(REPEAT_TICKS - 1);

  rpt_state_t        state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              repeat_pulse_q, repeat_pulse_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rcnt_q         <= '0;
      repeat_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rcnt_q         <= rcnt_d;
      repeat_pulse_q <= repeat_pulse_d;
    end
  end

  // Keyed off db_out_d so a release on a tick edge pre-empts any pulse due
  // on that same edge, and the press edge itself only arms the counter.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    if (!db_out_d) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = HOLD;
          rcnt_d  = '0;
        end
        HOLD: begin
          if (tick) begin
            if (rcnt_q == HOLD_LAST) begin
              state_d = REPEAT;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + RCNT_W'(1);
            end
          end
        end
        REPEAT: begin
          if (tick) begin
            if (rcnt_q == REPEAT_LAST) begin
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + RCNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    repeat_pulse_d = 1'b0;
    if (db_out_d && tick) begin
      if ((state_q == HOLD && rcnt_q == HOLD_LAST) ||
          (state_q == REPEAT && rcnt_q == REPEAT_LAST)) begin
        repeat_pulse_d = 1'b1;
      end
    end
  end

  assign repeat_pulse = repeat_pulse_q;

`else

  // Repeat timing parameters are accepted for drop-in compatibility only.
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ((HOLD_TICKS + REPEAT_TICKS) != 0);
  assign repeat_pulse   = 1'b0;

`endif

endmodule
